// File: rtl/mult_arbiter.sv
// ---------------------------------------------------------------------------
// mult_arbiter
// Shares one STAGES-deep pipelined multiplier chain among NUM_REQ requesters.
// A round-robin arbiter issues at most one operation per cycle. A tag pipe
// follows each operation down the chain so the product can be returned to the
// requester that issued it. Each requester has one result buffer, which holds
// the product until the requester acknowledges it.
//
// Optional feature: define MULT_ARB_PERF_EN to add the saturating performance
// counters perf_issue_cnt and perf_stall_cnt.
//
// Ports:
//   clock, reset   : system clock, synchronous active-high reset
//   req_valid      : per-requester request valid
//   req_ready      : per-requester accept, combinational, one-hot or zero
//   req_mcand      : packed multiplicands, requester i at [i*WIDTH +: WIDTH]
//   req_mplier     : packed multipliers, same packing
//   rsp_valid      : a result is held for requester i
//   rsp_product    : packed held results
//   rsp_ack        : requester consumes its held result
//   mult_start     : registered start to the chain
//   mult_mcand     : registered multiplicand to the chain
//   mult_mplier    : registered multiplier to the chain
//   mult_done      : chain done (last stage)
//   mult_product   : chain product (last stage)
//   err_latency    : sticky flag; mult_done disagreed with the tag pipe
//   perf_issue_cnt : (MULT_ARB_PERF_EN) saturating count of handshakes
//   perf_stall_cnt : (MULT_ARB_PERF_EN) saturating count of stalled cycles
// ---------------------------------------------------------------------------
module mult_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int STAGES  = 4,
   parameter int WIDTH   = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_mcand,
   input  logic [NUM_REQ*WIDTH-1:0] req_mplier,
   output logic [NUM_REQ-1:0]       rsp_valid,
   output logic [NUM_REQ*WIDTH-1:0] rsp_product,
   input  logic [NUM_REQ-1:0]       rsp_ack,
   output logic                     mult_start,
   output logic [WIDTH-1:0]         mult_mcand,
   output logic [WIDTH-1:0]         mult_mplier,
   input  logic                     mult_done,
   input  logic [WIDTH-1:0]         mult_product,
`ifdef MULT_ARB_PERF_EN
   output logic [15:0]              perf_issue_cnt,
   output logic [15:0]              perf_stall_cnt,
`endif
   output logic                     err_latency
);

   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   typedef logic [IDW-1:0] id_t;
   localparam id_t LAST_ID = id_t'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } req_state_t;

   // ---------------- arbitration ----------------
   logic [NUM_REQ-1:0] idle_vec;
   logic               grant_found;
   id_t                grant_id;
   id_t                rr_ptr_reg;
   id_t                rr_ptr_next;

   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      // Scan from rr_ptr upward with wrap; the first eligible requester wins.
      for (int k = 0; k < NUM_REQ; k++) begin
         int idx;
         idx = int'(rr_ptr_reg) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!grant_found && req_valid[idx] && idle_vec[idx]) begin
            grant_found = 1'b1;
            grant_id    = id_t'(idx);
         end
      end
   end

   always_comb begin
      rr_ptr_next = rr_ptr_reg;
      if (grant_found) begin
         rr_ptr_next = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
      end
   end

   // ---------------- issue registers ----------------
   logic             mult_start_reg;
   logic [WIDTH-1:0] mult_mcand_reg;
   logic [WIDTH-1:0] mult_mplier_reg;
   id_t              issue_id_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr_reg      <= '0;
         mult_start_reg  <= 1'b0;
         mult_mcand_reg  <= '0;
         mult_mplier_reg <= '0;
         issue_id_reg    <= '0;
      end else begin
         rr_ptr_reg      <= rr_ptr_next;
         mult_start_reg  <= grant_found;
         mult_mcand_reg  <= grant_found ? req_mcand[grant_id*WIDTH +: WIDTH] : '0;
         mult_mplier_reg <= grant_found ? req_mplier[grant_id*WIDTH +: WIDTH] : '0;
         issue_id_reg    <= grant_id;
      end
   end

   assign mult_start  = mult_start_reg;
   assign mult_mcand  = mult_mcand_reg;
   assign mult_mplier = mult_mplier_reg;

   // ---------------- tag pipe ----------------
   // Entry 0 is loaded one cycle after mult_start, so the last entry lines up
   // with mult_done of the same operation.
   logic [STAGES-1:0] tag_valid_reg;
   id_t               tag_id_reg [STAGES];

   always_ff @(posedge clock) begin
      if (reset) begin
         tag_valid_reg[0] <= 1'b0;
         tag_id_reg[0]    <= '0;
      end else begin
         tag_valid_reg[0] <= mult_start_reg;
         tag_id_reg[0]    <= issue_id_reg;
      end
   end

   generate
      for (genvar gi = 1; gi < STAGES; gi++) begin : g_tag
         always_ff @(posedge clock) begin
            if (reset) begin
               tag_valid_reg[gi] <= 1'b0;
               tag_id_reg[gi]    <= '0;
            end else begin
               tag_valid_reg[gi] <= tag_valid_reg[gi-1];
               tag_id_reg[gi]    <= tag_id_reg[gi-1];
            end
         end
      end
   endgenerate

   logic tag_last_valid;
   id_t  tag_last_id;
   logic capture;
   logic mismatch;

   assign tag_last_valid = tag_valid_reg[STAGES-1];
   assign tag_last_id    = tag_id_reg[STAGES-1];
   assign capture        = mult_done & tag_last_valid;
   // A done with no tag, or a tag with no done: the chain latency is wrong.
   assign mismatch       = mult_done ^ tag_last_valid;

   // ---------------- per-requester FSM and result buffer ----------------
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
         req_state_t       state_reg;
         req_state_t       state_next;
         logic [WIDTH-1:0] product_reg;
         logic             granted;
         logic             returned;

         assign granted  = grant_found && (grant_id == id_t'(gi));
         assign returned = capture && (tag_last_id == id_t'(gi));

         always_comb begin
            state_next = state_reg;
            case (state_reg)
               ST_IDLE: if (granted)     state_next = ST_BUSY;
               ST_BUSY: if (returned)    state_next = ST_DONE;
               ST_DONE: if (rsp_ack[gi]) state_next = ST_IDLE;
               default:                  state_next = ST_IDLE;
            endcase
         end

         always_ff @(posedge clock) begin
            if (reset) begin
               state_reg   <= ST_IDLE;
               product_reg <= '0;
            end else begin
               state_reg <= state_next;
               if (returned) begin
                  product_reg <= mult_product;
               end
            end
         end

         assign idle_vec[gi]                   = (state_reg == ST_IDLE);
         assign req_ready[gi]                  = granted;
         assign rsp_valid[gi]                  = (state_reg == ST_DONE);
         assign rsp_product[gi*WIDTH +: WIDTH] = product_reg;
      end
   endgenerate

   // ---------------- error flag ----------------
   logic err_latency_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         err_latency_reg <= 1'b0;
      end else if (mismatch) begin
         err_latency_reg <= 1'b1;
      end
   end

   assign err_latency = err_latency_reg;

`ifdef MULT_ARB_PERF_EN
   // ---------------- performance counters ----------------
   logic [15:0] issue_cnt_reg;
   logic [15:0] stall_cnt_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         issue_cnt_reg <= '0;
         stall_cnt_reg <= '0;
      end else begin
         if (grant_found && (issue_cnt_reg != 16'hFFFF)) begin
            issue_cnt_reg <= issue_cnt_reg + 16'd1;
         end
         if ((|req_valid) && !grant_found && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
         end
      end
   end

   assign perf_issue_cnt = issue_cnt_reg;
   assign perf_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mult_arbiter
// Bench for mult_arbiter with a 4-deep multiplier chain model. The stimulus
// process predicts grants and result timing from a requester-level model and
// pushes expected results into a scoreboard queue. A separate monitor pops an
// entry whenever a rsp_valid bit rises.
// ---------------------------------------------------------------------------
module tb_mult_arbiter;

   localparam int N  = 4;
   localparam int ST = 4;
   localparam int W  = 16;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_mcand = '0;
   logic [N*W-1:0] req_mplier = '0;
   logic [N-1:0]   rsp_valid;
   logic [N*W-1:0] rsp_product;
   logic [N-1:0]   rsp_ack = '0;
   logic           mult_start;
   logic [W-1:0]   mult_mcand;
   logic [W-1:0]   mult_mplier;
   logic           mult_done;
   logic [W-1:0]   mult_product;
   logic           err_latency;
   logic           force_done = 1'b0;
`ifdef MULT_ARB_PERF_EN
   logic [15:0]    perf_issue_cnt;
   logic [15:0]    perf_stall_cnt;
`endif

   always #5 clock = ~clock;

   mult_arbiter #(.NUM_REQ(N), .STAGES(ST), .WIDTH(W)) dut (
      .clock        (clock),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_mcand    (req_mcand),
      .req_mplier   (req_mplier),
      .rsp_valid    (rsp_valid),
      .rsp_product  (rsp_product),
      .rsp_ack      (rsp_ack),
      .mult_start   (mult_start),
      .mult_mcand   (mult_mcand),
      .mult_mplier  (mult_mplier),
      .mult_done    (mult_done),
      .mult_product (mult_product),
`ifdef MULT_ARB_PERF_EN
      .perf_issue_cnt (perf_issue_cnt),
      .perf_stall_cnt (perf_stall_cnt),
`endif
      .err_latency  (err_latency)
   );

   // ---------------- multiplier chain model ----------------
   logic [ST-1:0] ch_v;
   logic [W-1:0]  ch_p [ST];

   always @(posedge clock) begin
      if (reset) begin
         ch_v <= '0;
         for (int k = 0; k < ST; k++) ch_p[k] <= '0;
      end else begin
         ch_v    <= {ch_v[ST-2:0], mult_start};
         ch_p[0] <= mult_mcand * mult_mplier;
         for (int k = 1; k < ST; k++) ch_p[k] <= ch_p[k-1];
      end
   end

   assign mult_done    = ch_v[ST-1] | force_done;
   assign mult_product = ch_p[ST-1];

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   typedef struct {
      int          id;
      logic [15:0] prod;
   } exp_t;
   exp_t exp_q[$];

   // ---------------- reference model state ----------------
   int          m_ptr;
   bit          m_busy [N];
   int          m_rdy  [N];
   bit          m_err;
   bit          m_pgo;
   logic [15:0] m_pa;
   logic [15:0] m_pb;

   // stimulus controls
   logic [15:0] op_a [N];
   logic [15:0] op_b [N];
   logic [N-1:0] drv_v  = '0;
   logic [N-1:0] ack_en = '0;
   bit rst_drv   = 1'b1;
   bit force_drv = 1'b0;
   bit rand_ack  = 1'b0;

   function automatic bit m_done(input int i);
      return m_busy[i] && (cyc >= m_rdy[i]);
   endfunction

   task automatic model_reset();
      m_ptr = 0;
      m_err = 1'b0;
      m_pgo = 1'b0;
      m_pa  = '0;
      m_pb  = '0;
      for (int i = 0; i < N; i++) begin
         m_busy[i] = 1'b0;
         m_rdy[i]  = 0;
      end
      exp_q.delete();
   endtask

   task automatic do_cycle();
      logic [N-1:0] ack;
      logic [N-1:0] exp_rv;
      logic [N-1:0] exp_rdy;
      int g;
      longint prod;
      exp_t e;
      @(posedge clock);
      cyc++;
      #1;
      reset      = rst_drv;
      force_done = force_drv;
      req_valid  = drv_v;
      for (int i = 0; i < N; i++) begin
         req_mcand[i*W +: W]  = op_a[i];
         req_mplier[i*W +: W] = op_b[i];
         ack[i] = ack_en[i] & (rand_ack ? 1'($urandom_range(0, 1)) : 1'b1);
      end
      rsp_ack = ack;
      @(negedge clock);
      if (rst_drv) begin
         model_reset();
         return;
      end
      for (int i = 0; i < N; i++) exp_rv[i] = m_done(i);
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      chk("err_latency", 32'(err_latency), 32'(m_err));
      chk("mult_start", 32'(mult_start), 32'(m_pgo));
      chk("mult_mcand", 32'(mult_mcand), 32'(m_pa));
      chk("mult_mplier", 32'(mult_mplier), 32'(m_pb));
      // round robin from the model pointer
      g = -1;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (m_ptr + k) % N;
         if (g < 0 && drv_v[idx] && !m_busy[idx]) g = idx;
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      for (int i = 0; i < N; i++) begin
         if (ack[i] && m_done(i)) m_busy[i] = 1'b0;
      end
      m_pgo = (g >= 0);
      m_pa  = (g >= 0) ? op_a[g] : 16'h0;
      m_pb  = (g >= 0) ? op_b[g] : 16'h0;
      if (g >= 0) begin
         m_busy[g] = 1'b1;
         m_rdy[g]  = cyc + 2 + ST;
         prod      = (longint'(op_a[g]) * longint'(op_b[g])) % 65536;
         e.id      = g;
         e.prod    = 16'(prod);
         exp_q.push_back(e);
         m_ptr     = (g + 1) % N;
      end
      if (force_drv) m_err = 1'b1;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) do_cycle();
   endtask

   // ---------------- monitor ----------------
   logic [N-1:0] prev_rv = '0;
   logic [15:0]  held [N];

   always @(negedge clock) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) begin
            if (rsp_valid[i] && !prev_rv[i]) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL sb_underflow cycle %0d: rsp_valid[%0d] rose, expected no result", cyc, i);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  chk("rsp_id", 32'(i), 32'(e.id));
                  chk("rsp_product", 32'(rsp_product[i*W +: W]), 32'(e.prod));
                  held[i] = e.prod;
                  $display("cycle %0d: req %0d result %04h (expected %04h)",
                           cyc, i, rsp_product[i*W +: W], e.prod);
               end
            end else if (rsp_valid[i]) begin
               chk("rsp_hold", 32'(rsp_product[i*W +: W]), 32'(held[i]));
            end
         end
      end
      prev_rv = rsp_valid;
   end

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < N; i++) begin
         op_a[i] = '0;
         op_b[i] = '0;
      end
      model_reset();

      // reset
      rst_drv = 1'b1;
      run(3);
      rst_drv = 1'b0;
      run(1);
      for (int i = 0; i < N; i++) chk("rst_product", 32'(rsp_product[i*W +: W]), 32'h0);

      // single op: requester 0, 3*5
      ack_en  = '1;
      op_a[0] = 16'd3;
      op_b[0] = 16'd5;
      drv_v   = 4'b0001;
      run(1);
      drv_v   = 4'b0000;
      run(10);

      // back-to-back, all requesters valid, immediate acks
      drv_v = 4'b1111;
      for (int k = 0; k < 30; k++) begin
         for (int i = 0; i < N; i++) begin
            op_a[i] = 16'($urandom);
            op_b[i] = 16'($urandom);
         end
         do_cycle();
      end
      drv_v = 4'b0000;
      run(10);

      // requester 1 withholds its ack
      ack_en = 4'b1101;
      drv_v  = 4'b1111;
      run(20);
      ack_en = 4'b1111;
      drv_v  = 4'b0000;
      run(10);

      // overflow cases
      op_a[2] = 16'h0100; op_b[2] = 16'h0100;
      op_a[3] = 16'hFFFF; op_b[3] = 16'hFFFF;
      drv_v   = 4'b1100;
      run(2);
      drv_v   = 4'b0000;
      run(10);

      // reset with two ops in flight
      op_a[0] = 16'd11; op_b[0] = 16'd13;
      op_a[1] = 16'd17; op_b[1] = 16'd19;
      drv_v   = 4'b0011;
      run(2);
      drv_v   = 4'b0000;
      run(1);
      rst_drv = 1'b1;
      run(1);
      rst_drv = 1'b0;
      run(10);
      op_a[0] = 16'd7; op_b[0] = 16'd9;
      drv_v   = 4'b0001;
      run(1);
      drv_v   = 4'b0000;
      run(10);

      // done with an empty tag pipe
      force_drv = 1'b1;
      run(1);
      force_drv = 1'b0;
      run(6);
      rst_drv = 1'b1;
      run(1);
      rst_drv = 1'b0;
      run(3);

      // randomized traffic with random acks
      rand_ack = 1'b1;
      for (int k = 0; k < 300; k++) begin
         drv_v = 4'($urandom);
         for (int i = 0; i < N; i++) begin
            op_a[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            op_b[i] = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
         end
         do_cycle();
      end
      rand_ack = 1'b0;
      drv_v    = 4'b0000;
      run(12);
      chk("sb_drained", 32'(exp_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one STAGES-deep pipelined 16-bit multiplier chain among NUM_REQ requesters.
- Round-robin arbitration issues at most one operation per cycle into the chain.
- Tracks the owner of each in-flight operation with a tag pipe aligned to the chain's done output, and holds each result in a per-requester buffer until acknowledged.
- Sits between client blocks and the multiplier chain; the chain's first-stage product_in is tied to 0 at the top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- STAGES, 4, multiplier chain latency in cycles from mult_start to mult_done.
- WIDTH, 16, operand/product width (low WIDTH bits of the product returned).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant/accept (combinational)
- req_mcand  in  NUM_REQ*WIDTH  packed multiplicands, requester i at [i*WIDTH +: WIDTH]
- req_mplier  in  NUM_REQ*WIDTH  packed multipliers, same packing
- rsp_valid  out  NUM_REQ  result held for requester i
- rsp_product  out  NUM_REQ*WIDTH  packed held results
- rsp_ack  in  NUM_REQ  requester consumes held result
- mult_start  out  1  registered start to chain
- mult_mcand  out  WIDTH  registered multiplicand to chain
- mult_mplier  out  WIDTH  registered multiplier to chain
- mult_done  in  1  chain done (last stage)
- mult_product  in  WIDTH  chain product (last stage)
- err_latency  out  1  sticky protocol error flag

Behaviour:
- Per-requester state: IDLE -> BUSY on handshake; BUSY -> DONE when its tag exits with mult_done; DONE -> IDLE on rsp_ack. At most one outstanding op per requester.
- Grant (combinational): among i with req_valid[i] and state[i]==IDLE, pick the first at or after rr_ptr (wrapping). req_ready is one-hot or zero. Handshake = req_valid & req_ready.
- On handshake for requester g: rr_ptr <= (g+1) mod NUM_REQ. rr_ptr is unchanged when there is no grant.
- Issue registers, updated every cycle:
  - mult_start <= handshake.
  - mult_mcand/mult_mplier <= granted operands, or 0 when there is no grant.
- Tag pipe: STAGES entries of {valid, id}. Entry 0 <= {mult_start, id of registered issue}; shifts every cycle. The last entry aligns with mult_done.
- Latency, handshake at cycle 0: mult_start high in cycle 1; mult_done expected in cycle 1+STAGES; rsp_valid high from cycle 2+STAGES. The buffer captures mult_product on the edge where mult_done and the tag are valid.
- rsp_valid[i] = (state[i]==DONE). rsp_product holds until ack. rsp_ack while not DONE is ignored.
- A requester may re-request in the same cycle its ack is taken only from the next cycle; ack and a new grant never coincide for the same i.
- Mismatch (mult_done != last tag valid): err_latency <= 1, sticky until reset. No result is written on a mismatch.
- Reset, including mid-operation:
  - All states IDLE, rr_ptr=0, tag pipe cleared.
  - mult_start=0, mult_mcand=0, mult_mplier=0.
  - rsp_valid=0, rsp_product=0, err_latency=0.
  - In-flight ops are dropped; the chain is reset by the same reset.
- Back-to-back: with all requesters eligible, one issue per cycle, grant order 0,1,2,3,0...

Optional Feature:
- MULT_ARB_PERF_EN defined:
  - Adds output perf_issue_cnt (16 bits), the count of handshakes, saturating at 0xFFFF.
  - Adds output perf_stall_cnt (16 bits), the count of cycles with any req_valid but no grant, saturating.
  - Both counters are 0 on reset.
- Undefined: neither port nor counter logic exists.

Test Plan:
- Single op: req0 mcand=3, mplier=5 at cycle 0 -> mult_start cycle 1; rsp_valid[0] cycle 6 with product 15; rsp_ack -> state IDLE next cycle.
- All four requesters valid continuously, acks returned immediately -> grants 0,1,2,3; rsp_valid at cycles 6,7,8,9 with correct products; rr_ptr wraps to 0.
- Requester 1 withholds ack -> no new grant to 1 while DONE; others keep issuing; product stays stable until ack.
- Overflow: 0x0100*0x0100 -> rsp_product 0x0000; 0xFFFF*0xFFFF -> 0x0001.
- Reset asserted in cycle 3 with two ops in flight -> all rsp_valid stay 0; err_latency=0; a new request after reset completes normally.
- Force mult_done high with an empty tag pipe -> err_latency=1 next cycle and stays 1 until reset; no rsp_valid asserted.
